// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the clearable single-port RAM
package ram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam int RDW_ZERO = 0;
  localparam int RDW_THRU = 1;

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// rtl/ram_clr_seq.sv - clear sweep sequencer: walks every address once after reset or clr_req
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + AW'(1);
          // All-ones count means the last word is being cleared on this edge.
          if (&cnt) begin
            state <= S_READY;
            busy  <= 1'b0;
          end
        end
        S_READY: begin
          if (clr_req) begin
            state <= S_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == S_CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - single-port synchronous RAM with read pipeline and clear engine
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DW       = 4,
  parameter int AW       = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          csn,
  input  logic          rwn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          rvalid,
  input  logic          clr_req,
  output logic          busy,
  output logic          acc_err
);

  localparam int DEPTH = 2 ** AW;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("ram_sp_clr: RD_LAT must be 1 or 2");
  end

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  ram_clr_seq #(.AW(AW)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic          acc;
  logic          flush;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] rdw_val;

  // clr_req wins over a same-edge access; the access is reported via acc_err.
  assign acc       = !csn && !busy && !clr_req;
  assign flush     = clr_req && !busy;
  assign mem_we    = clr_we || (acc && !rwn);
  assign mem_addr  = clr_we ? clr_addr : addr;
  assign mem_wdata = clr_we ? '0 : data_in;
  assign rdw_val   = (RDW_MODE == RDW_THRU) ? data_in : '0;

  // Storage deliberately has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  logic          out_upd;
  logic          out_vld;
  logic [DW-1:0] out_data;

  if (RD_LAT == 2) begin : g_lat2
    logic          p_upd;
    logic          p_vld;
    logic [DW-1:0] p_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_upd  <= 1'b0;
        p_vld  <= 1'b0;
        p_data <= '0;
      end else if (flush) begin
        p_upd  <= 1'b0;
        p_vld  <= 1'b0;
      end else begin
        p_upd  <= acc;
        p_vld  <= acc && rwn;
        p_data <= rwn ? mem[addr] : rdw_val;
      end
    end

    assign out_upd  = p_upd;
    assign out_vld  = p_vld;
    assign out_data = p_data;
  end else begin : g_lat1
    assign out_upd  = acc;
    assign out_vld  = acc && rwn;
    assign out_data = rwn ? mem[addr] : rdw_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rvalid   <= 1'b0;
      acc_err  <= 1'b0;
    end else begin
      acc_err <= !csn && (busy || clr_req);
      if (flush) begin
        data_out <= '0;
        rvalid   <= 1'b0;
      end else if (out_upd) begin
        data_out <= out_data;
        rvalid   <= out_vld;
      end else begin
        rvalid   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
- Parametrised single-port synchronous RAM; generalises the CPU's 16x4 data/program store to arbitrary width/depth.
- Adds selectable read latency (1 or 2), selectable read-during-write output, read-valid strobe and a sequential clear engine.
- The clear engine lets the array map onto inferred block RAM: no asynchronous reset of storage.
- Sits between the CPU datapath/control unit and memory; the control unit must respect `busy`.

Parameters:
- DW, 4, data word width (bits).
- AW, 4, address width; DEPTH = 2**AW words.
- RD_LAT, 1, read latency in clock edges; legal values 1 or 2.
- RDW_MODE, 0, data_out on a write: 0 = forced to 0; 1 = write-through (data_in).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- csn  input  1  chip select, active-low.
- rwn  input  1  1 = read, 0 = write (sampled only when csn=0).
- addr  input  AW  word address.
- data_in  input  DW  write data.
- data_out  output  DW  read data (registered).
- rvalid  output  1  one-cycle strobe: data_out holds new read data.
- clr_req  input  1  request a full-array clear (level sampled at posedge).
- busy  output  1  clear sweep in progress; accesses are not accepted.
- acc_err  output  1  one-cycle pulse: access attempted while busy or dropped by clr_req.

Behaviour:
- Reset values (rst_n=0, asynchronous):
  - data_out=0, rvalid=0, acc_err=0, busy=1.
  - FSM=S_CLEAR, clear counter=0, read pipeline flushed.
  - Array contents are not reset by rst_n.
- FSM states: S_CLEAR and S_READY.
- S_CLEAR:
  - Each posedge writes 0 to mem[cnt], then cnt++.
  - At the posedge clearing address DEPTH-1: go to S_READY, busy=0 after that edge.
  - Sweep length is exactly DEPTH edges.
- S_READY, clr_req=1 at posedge:
  - Go to S_CLEAR, cnt=0, busy=1, data_out=0, rvalid=0.
  - Any in-flight RD_LAT=2 read is dropped.
  - clr_req has priority over a simultaneous access. The access is ignored and acc_err=1 for one cycle if csn=0.
- Access while busy (S_CLEAR):
  - csn=0 is ignored and memory is untouched.
  - acc_err pulses for each such edge.
  - data_out stays 0; rvalid stays 0.
  - clr_req while busy is ignored; the sweep is not restarted.
- Read (S_READY, csn=0, rwn=1) sampled at edge N:
  - RD_LAT=1: data_out=mem[addr] and rvalid=1 after edge N.
  - RD_LAT=2: same update after edge N+1. Back-to-back reads give one result per cycle.
- Write (csn=0, rwn=0) at edge N:
  - mem[addr] is updated at edge N.
  - data_out = 0 (RDW_MODE=0) or data_in (RDW_MODE=1), delayed per RD_LAT. rvalid=0 for that slot.
- Idle (csn=1): data_out holds its last value; rvalid=0.
- Read-after-write: a read of the same address at edge N+1 returns the new data. There is no stale bypass path.
- rvalid and acc_err are single-cycle pulses, not sticky.
- Reset asserted mid-sweep or mid-read: immediate return to reset values; the sweep restarts from address 0 after release.
- addr is always in range (DEPTH = 2**AW), so no wrap handling is needed.
- rwn and addr are don't-care when csn=1.

Decomposition:
- Shared package ram_pkg:
  - state encoding S_CLEAR/S_READY.
  - RDW_MODE constants RDW_ZERO=0, RDW_THRU=1.
  - helper function for legal RD_LAT checking (elaboration assertion).
- Optional sub-module ram_clr_seq (counter + FSM, outputs busy/clr_we/clr_addr). The array and read pipeline stay in ram_sp_clr.

Test Plan (DW=4, AW=4, unless stated):
- Release reset -> busy=1 for exactly 16 edges, then 0. A subsequent read of each of addr 0..15 returns 0 with rvalid=1 one edge later.
- Write addr 3 = 4'hA, then read addr 3 on the next edge -> data_out=4'hA, rvalid=1 after the read edge. With RD_LAT=2, the same result appears one edge later; back-to-back reads of 0..15 stream one word per cycle.
- RDW_MODE=0: write 4'h5 -> data_out=0. RDW_MODE=1: write 4'h5 -> data_out=4'h5, rvalid=0 in both cases.
- Fill the array with 4'hF, then assert clr_req and csn=0 on the same edge:
  - the write is dropped and acc_err pulses.
  - busy=1 for 16 edges, and reads during the sweep produce acc_err with no rvalid.
  - after the sweep, all words read 0.
- Assert rst_n=0 at sweep edge 7 and with an RD_LAT=2 read in flight -> outputs return to reset values immediately, no rvalid. After release the sweep restarts and takes 16 edges.
- DW=8, AW=6 -> sweep takes 64 edges. Write 8'hC3 to addr 63 and read it back as 8'hC3. Address 0 unaffected.
